fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch buffer between instruction memory and the decode stage (feeds op/funct3/funct7b5
//  to the controller). Fetches sequentially from a local PC, queues {pc, instr} pairs in a DEPTH-entry FIFO,
//  presents the head to decode under a valid/ready handshake and flushes on a redirect (branch/jump/jalr).
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >= 2
//  XLEN      32            address/instruction width
//  RESET_PC  32'h0000_0000 fetch address after reset
// PORTS
//  clk            in   1     clock, all state on rising edge
//  reset          in   1     synchronous, active-high
//  fetch_en       in   1     1 = fetching permitted this cycle
//  imem_addr      out  XLEN  = fetch_pc register (combinational read of imem)
//  imem_rdata     in   XLEN  instruction at imem_addr, same cycle
//  redirect_valid in   1     flush queue, restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch PC; bits[1:0] forced to 0
//  valid_d        out  1     head entry valid (queue non-empty)
//  ready_d        in   1     decode accepts head this cycle (0 = stall)
//  instr_d        out  XLEN  head instruction; 32'h0000_0013 (NOP) when empty
//  pc_d           out  XLEN  head PC; 0 when empty
//  pcplus4_d      out  XLEN  pc_d + 4 (mod 2^XLEN); 0 when empty
//  full           out  1     count == DEPTH
//  op_d           out  7     predecode, see CONFIGURATION
//  funct3_d       out  3     predecode
//  funct7b5_d     out  1     predecode
//  is_ctrl_d      out  1     predecode
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, wr_ptr=rd_ptr=0, count=0; valid_d=0, instr_d=NOP, pc_d=0, pcplus4_d=0,
//    full=0, predecode outputs 0. Reset overrides redirect, push and pop in the same cycle.
//  - pop  = valid_d & ready_d.
//  - push = fetch_en & ~redirect_valid & (count < DEPTH | pop); writes {fetch_pc, imem_rdata} at wr_ptr,
//    fetch_pc <= fetch_pc + 4 (wraps mod 2^XLEN). No push: fetch_pc holds.
//  - Full + pop + push in same cycle allowed; count unchanged. Empty: pop impossible (valid_d=0).
//  - Pointers wrap modulo DEPTH; count range 0..DEPTH, never over/underflows.
//  - Latency: entry pushed at edge N is on valid_d/instr_d from cycle N+1 (outputs driven from FIFO head).
//  - Redirect (priority over push/pop): queue cleared (count=0, pointers 0), fetch_pc <= {redirect_pc[XLEN-1:2],2'b00},
//    no push that cycle; head shown in the redirect cycle is discarded whether or not ready_d=1
//    (decode flushes its own copy). Redirect at cycle N -> imem_addr=redirect_pc at N+1 -> valid_d at N+2
//    if fetch_en=1 at N+1.
//  - Back-to-back redirects: the later one wins; queue stays empty.
//  - fetch_en=0 with ready_d=1 drains the queue; valid_d falls after last entry.
// CONFIGURATION
//  FETCHQ_PREDECODE_EN defined: op_d=instr_d[6:0], funct3_d=instr_d[14:12], funct7b5_d=instr_d[30],
//    is_ctrl_d=valid_d & (op_d in {7'b1100011, 7'b1101111, 7'b1100111}); all 0 while valid_d=0.
//  Undefined: op_d, funct3_d, funct7b5_d, is_ctrl_d tied to 0; no predecode logic. Queue behaviour identical.
// TESTING
//  1. Reset, fetch_en=1, ready_d=1, imem[i]=i -> imem_addr 0,4,8..; valid_d from cycle 2, pc_d 0,4,8 one per cycle.
//  2. ready_d=0, fetch_en=1 from reset -> full=1 after 4 pushes, imem_addr holds 0x10, pc_d holds 0.
//  3. Full, ready_d=1 for 1 cycle -> pc_d 0->4, entry 0x10 pushed same cycle, full stays 1.
//  4. Queue holding 0x8..0x14, redirect_pc=0x103 -> next cycle valid_d=0, imem_addr=0x100; cycle after pc_d=0x100.
//  5. Redirect and reset same cycle -> imem_addr=RESET_PC, valid_d=0.
//  6. FETCHQ_PREDECODE_EN, head instr 0x0000_0463 (beq) -> op_d=7'h63, funct3_d=0, is_ctrl_d=1; macro off -> all 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry {pc, instr} FIFO, head presented to decode.
// Optional predecode of the head entry is enabled by defining FETCHQ_PREDECODE_EN.
module fetch_queue #(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            valid_d,
   input  logic            ready_d,
   output logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pcplus4_d,
   output logic            full,
   output logic [6:0]      op_d,
   output logic [2:0]      funct3_d,
   output logic            funct7b5_d,
   output logic            is_ctrl_d
);

   localparam int unsigned     AW  = $clog2(DEPTH);
   localparam int unsigned     CW  = AW + 1;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            push, pop, nonempty;

   assign nonempty  = (count_q != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign pop       = nonempty & ready_d;
   // A full queue may still accept a push when the head leaves in the same cycle.
   assign push      = fetch_en & ~redirect_valid & (~full | pop);
   assign imem_addr = fetch_pc_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   assign valid_d   = nonempty;
   assign instr_d   = nonempty ? instr_mem_q[rd_ptr_q] : NOP;
   assign pc_d      = nonempty ? pc_mem_q[rd_ptr_q] : '0;
   assign pcplus4_d = nonempty ? pc_mem_q[rd_ptr_q] + XLEN'(4) : '0;

`ifdef FETCHQ_PREDECODE_EN
   always_comb begin
      op_d       = '0;
      funct3_d   = '0;
      funct7b5_d = 1'b0;
      is_ctrl_d  = 1'b0;
      if (nonempty) begin
         op_d       = instr_d[6:0];
         funct3_d   = instr_d[14:12];
         funct7b5_d = instr_d[30];
         is_ctrl_d  = (instr_d[6:0] == 7'b1100011) || (instr_d[6:0] == 7'b1101111) ||
                      (instr_d[6:0] == 7'b1100111);
      end
   end
`else
   assign op_d       = '0;
   assign funct3_d   = '0;
   assign funct7b5_d = 1'b0;
   assign is_ctrl_d  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver issues stimulus and queues expected entries; monitor checks the head.
module tb_fetch_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset, fetch_en, redirect_valid, ready_d;
   logic [31:0] redirect_pc, imem_addr, imem_rdata;
   logic        valid_d, full, funct7b5_d, is_ctrl_d;
   logic [31:0] instr_d, pc_d, pcplus4_d;
   logic [6:0]  op_d;
   logic [2:0]  funct3_d;

   logic [31:0] imem [256];
   ent_t        exp_q [$];
   logic [31:0] mdl_pc;
   int          total = 0;
   int          bad   = 0;

   fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .valid_d(valid_d), .ready_d(ready_d), .instr_d(instr_d), .pc_d(pc_d),
      .pcplus4_d(pcplus4_d), .full(full), .op_d(op_d), .funct3_d(funct3_d),
      .funct7b5_d(funct7b5_d), .is_ctrl_d(is_ctrl_d)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr[9:2]];

   function automatic logic [11:0] pd_exp(input logic [31:0] ins, input bit v);
      logic [6:0] op;
      op = ins[6:0];
`ifdef FETCHQ_PREDECODE_EN
      if (v) return {(op == 7'h63 || op == 7'h6f || op == 7'h67), ins[30], ins[14:12], op};
`endif
      return 12'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: checks the presented head against the scoreboard, pops on an accepted transfer.
   initial begin
      ent_t e;
      bit   ev;
      forever begin
         @(negedge clk);
         #3;
         ev = (exp_q.size() != 0);
         chk("imem_addr", imem_addr, mdl_pc);
         chk("valid_d", {31'b0, valid_d}, {31'b0, ev});
         chk("full", {31'b0, full}, {31'b0, (exp_q.size() == 4)});
         if (ev) begin
            e = exp_q[0];
            chk("pc_d", pc_d, e.pc);
            chk("instr_d", instr_d, e.instr);
            chk("pcplus4_d", pcplus4_d, e.pc + 32'd4);
            chk("predecode", {20'b0, is_ctrl_d, funct7b5_d, funct3_d, op_d}, {20'b0, pd_exp(e.instr, 1'b1)});
         end else begin
            chk("empty_instr", instr_d, 32'h0000_0013);
            chk("empty_pc", pc_d, 32'h0);
            chk("empty_pcplus4", pcplus4_d, 32'h0);
            chk("empty_predecode", {20'b0, is_ctrl_d, funct7b5_d, funct3_d, op_d}, 32'h0);
         end
         if (ev && ready_d && !redirect_valid && !reset) void'(exp_q.pop_front());
      end
   end

   // Driver: applies one cycle of inputs, then records the expected effect of the coming edge.
   task automatic step(input bit rst, input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
      @(negedge clk);
      #2;
      reset = rst; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; ready_d = rdy;
      #2;
      if (rst) begin
         exp_q.delete();
         mdl_pc = 32'h0;
      end else if (rv) begin
         exp_q.delete();
         mdl_pc = rpc & ~32'h3;
      end else if (fe && exp_q.size() < 4) begin
         exp_q.push_back('{mdl_pc, imem[mdl_pc[9:2]]});
         mdl_pc = mdl_pc + 32'd4;
      end
   endtask

   initial begin
      logic [31:0] w, rpc;
      bit          rst, rv;
      logic [6:0]  ops [5];
      ops[0] = 7'h63; ops[1] = 7'h6f; ops[2] = 7'h67; ops[3] = 7'h13; ops[4] = 7'h33;
      for (int k = 0; k < 256; k++) begin
         if (k < 64) imem[k] = k;
         else begin
            w = $urandom;
            imem[k] = {w[31:7], ops[$urandom_range(0, 4)]};
         end
      end
      imem[64] = 32'h0000_0463;
      reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ready_d = 1'b0;
      mdl_pc = 32'h0;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (8) step(0, 1, 0, 0, 1);                 // streaming fetch/decode
      step(1, 0, 0, 0, 0);
      repeat (6) step(0, 1, 0, 0, 0);                 // fill until full, fetch_pc holds
      step(0, 1, 0, 0, 1);                            // pop and push while full
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'h0000_0103, 1);                // redirect discards accepted head
      repeat (3) step(0, 1, 0, 0, 0);
      step(1, 1, 1, 32'h0000_0200, 1);                // reset beats redirect
      step(0, 0, 0, 0, 0);
      repeat (5) step(0, 1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 1);                 // drain
      step(0, 1, 1, 32'h0000_0040, 1);
      step(0, 1, 1, 32'h0000_0080, 0);                // later redirect wins
      repeat (3) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'hFFFF_FFFD, 0);                // pc wrap
      repeat (3) step(0, 1, 0, 0, 0);
      repeat (4) step(0, 1, 0, 0, 1);

      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         rv  = !rst && ($urandom_range(0, 99) < 8);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 1023));
         step(rst, ($urandom_range(0, 3) != 0), rv, rpc, ($urandom_range(0, 2) != 0));
      end

      @(negedge clk);
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
